mosaic_run_ctrl: RTL

Board-level run controller between the PYNQ switches/LEDs and one or more mosaic `pipeline` instances. It synchronises and debounces the switches, then sequences each run: pipeline reset, run, completion/timeout detection. It reports state on the LEDs. It generalises the single-pipeline, hard-wired-switch-to-reset top level to N pipelines, single-shot/continuous modes, a timeout and a run counter.

---
 rtl/mosaic_ctrl_pkg.sv | 23 ++
 rtl/sw_debounce.sv | 44 ++++
 rtl/mosaic_run_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mosaic_ctrl_pkg.sv
// Shared types and index constants for the mosaic board-level run controller.
//   state_t   : run sequencer states
//   LED_*     : bit positions inside led_o
//   SW_*      : bit positions inside sw_i
package mosaic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int LED_DONE = 0;
    localparam int LED_BUSY = 1;
    localparam int LED_ERR  = 2;
    localparam int LED_HB   = 3;

    localparam int SW_RUN  = 0;
    localparam int SW_MODE = 1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a debouncer for one raw switch.
//   clk, reset : clock, async active-high reset
//   d_i        : raw (asynchronous) switch level
//   q_o        : debounced level; follows d_i after DEBOUNCE_CYCLES
//                consecutive disagreeing cycles (2 + DEBOUNCE_CYCLES total)
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          q_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            q_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            // Any cycle that agrees with the accepted level restarts the count.
            if (sync2_q == q_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                q_q   <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mosaic_run_ctrl.sv
// Board-level run controller for N mosaic pipelines.
//   clk, reset  : clock, async active-high reset
//   sw_i        : raw switches, [0] run request, [1] mode (1 = continuous)
//   pl_status_i : per-pipeline done level
//   pl_reset_o  : registered active-high reset to all pipelines
//   led_o       : [0] done, [1] busy, [2] error, [3] heartbeat,
//                 [NUM_LED-1:4] low bits of run_count_o (all lag state by 1)
//   run_count_o : saturating count of completed runs
module mosaic_run_ctrl
    import mosaic_ctrl_pkg::*;
#(
    parameter int N_PIPES         = 1,
    parameter int NUM_LED         = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int PL_RESET_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 1048576,
    parameter int HEARTBEAT_DIV   = 25000000,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         sw_i,
    input  logic [N_PIPES-1:0] pl_status_i,
    output logic               pl_reset_o,
    output logic [NUM_LED-1:0] led_o,
    output logic [CNT_W-1:0]   run_count_o
);

    localparam int RC_W = $clog2(PL_RESET_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HB_W = $clog2(HEARTBEAT_DIV + 1);

    logic [1:0] sw_db;

    for (genvar g = 0; g < 2; g++) begin : g_sw
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .d_i   (sw_i[g]),
            .q_o   (sw_db[g])
        );
    end

    logic run, mode, run_rise, all_done;
    logic run_prev_q;

    assign run      = sw_db[SW_RUN];
    assign mode     = sw_db[SW_MODE];
    assign run_rise = run & ~run_prev_q;
    assign all_done = &pl_status_i;

    state_t            state_q;
    logic              pl_reset_q;
    logic [RC_W-1:0]   rst_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CNT_W-1:0]  run_cnt_q;

    // pl_reset_q is updated alongside each transition so it reflects the
    // state being entered, keeping the pipeline reset glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pl_reset_q <= 1'b1;
            rst_cnt_q  <= '0;
            to_cnt_q   <= '0;
            run_cnt_q  <= '0;
            run_prev_q <= 1'b0;
        end else begin
            run_prev_q <= run;
            case (state_q)
                IDLE: begin
                    if (run_rise) begin
                        state_q   <= RST;
                        rst_cnt_q <= '0;
                    end
                end
                RST: begin
                    if (!run) begin
                        state_q <= IDLE;
                    end else if (rst_cnt_q == RC_W'(PL_RESET_CYCLES - 1)) begin
                        state_q    <= RUN;
                        pl_reset_q <= 1'b0;
                        to_cnt_q   <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
                RUN: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    // Completion wins over a coincident timeout or abort.
                    if (all_done) begin
                        state_q <= DONE;
                        if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + CNT_W'(1);
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q    <= ERR;
                        pl_reset_q <= 1'b1;
                    end else if (!run) begin
                        state_q    <= IDLE;
                        pl_reset_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Pipeline stays out of reset so its results can be read.
                    if (!run) begin
                        state_q    <= IDLE;
                        pl_reset_q <= 1'b1;
                    end else if (mode) begin
                        state_q    <= RST;
                        pl_reset_q <= 1'b1;
                        rst_cnt_q  <= '0;
                    end
                end
                ERR: begin
                    if (!run) state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    pl_reset_q <= 1'b1;
                end
            endcase
        end
    end

    logic [HB_W-1:0] hb_cnt_q;
    logic            hb_q;
    logic [3:0]      led_lo;
    logic [NUM_LED-1:0] led_d, led_q;

    always_comb begin
        led_lo           = '0;
        led_lo[LED_DONE] = (state_q == DONE);
        led_lo[LED_BUSY] = (state_q == RST) || (state_q == RUN);
        led_lo[LED_ERR]  = (state_q == ERR);
        led_lo[LED_HB]   = hb_q;
    end

    if (NUM_LED > 4) begin : g_led_wide
        logic [NUM_LED-5:0] led_hi;
        for (genvar i = 0; i < NUM_LED - 4; i++) begin : g_bit
            if (i < CNT_W) begin : g_cnt
                assign led_hi[i] = run_cnt_q[i];
            end else begin : g_zero
                assign led_hi[i] = 1'b0;
            end
        end
        assign led_d = {led_hi, led_lo};
    end else begin : g_led_narrow
        assign led_d = led_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
            led_q    <= '0;
        end else begin
            if (hb_cnt_q == HB_W'(HEARTBEAT_DIV - 1)) begin
                hb_cnt_q <= '0;
                hb_q     <= ~hb_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + HB_W'(1);
            end
            led_q <= led_d;
        end
    end

    assign pl_reset_o  = pl_reset_q;
    assign led_o       = led_q;
    assign run_count_o = run_cnt_q;

endmodule
